cfxp_block_accumulator: RTL and testbench
=========================================

Name: cfxp_block_accumulator

Overview:
Downstream stage of the complex fixed-point multiplier. Sums a block of complex products (real and imaginary channels independently) into one complex result per block, for the filter's lookback/lookahead dot-products. A block ends after `depth` accepted samples or earlier on `in_last`. Valid/ready handshakes on input and output let it absorb the multiplier's pipeline and stall against the consumer.

Parameters:
- n_int, 8, integer bits of the fixed-point format; sign bit is extra, word width n_tot+1 with n_tot = n_int + n_mant
- n_mant, 23, fractional bits
- depth, 16, samples per block; legal range 1..65535
- CNT_W, $clog2(depth+1), width of count (local parameter)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept input this cycle
- in_last  in  1  accepted sample closes the block early
- inR  in  n_tot+1 signed  real part of product
- inI  in  n_tot+1 signed  imaginary part of product
- out_valid  out  1  result held on resultR/resultI
- out_ready  in  1  consumer takes result
- resultR  out  n_tot+1 signed  accumulated real sum
- resultI  out  n_tot+1 signed  accumulated imaginary sum
- count  out  CNT_W  samples accepted in the open block

Behaviour:
- Interface: clk, single clock; rst is synchronous and active-high. All state updates on rising clk.
- Reset: out_valid=0, resultR=0, resultI=0, count=0, internal accR/accI=0, state ACC.
- Reset mid-block discards the partial sum. Reset while out_valid=1 drops the pending result.
- An input is accepted when in_valid && in_ready.
- An output is taken when out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational). Input may be accepted in the same cycle the result is taken.
- States:
  - ACC (out_valid=0)
  - HOLD (out_valid=1)
- ACC, accepted sample, not closing: acc <= (count==0 ? in : acc + in); count <= count+1.
- ACC, closing sample (count==depth-1 or in_last): result <= (count==0 ? in : acc + in); out_valid <= 1; count <= 0; go to HOLD.
- Latency: closing sample to out_valid high is 1 cycle.
- HOLD: resultR/resultI are stable until taken.
  - Taken with no input: out_valid <= 0, go to ACC.
  - Taken with an accepted input: that input starts a new block at count 0 under the ACC rules. If it also closes (depth==1 or in_last), out_valid stays 1 with the new result.
- in_last on the first sample emits that sample unchanged.
- depth==1: every accepted sample is emitted. Full throughput of 1 sample/cycle when out_ready is held high.
- Arithmetic: real and imaginary channels are independent. Sums are n_tot+1 bits, two's complement, with no extra guard bits in the output.
- Input signals other than in_valid are ignored when no input is accepted.
- count never exceeds depth-1.

Optional Feature:
- Macro: CFXP_ACC_SAT_EN.
- Defined: every addition saturates to +(2^n_tot - 1) or -(2^n_tot) per channel on signed overflow. Saturation is sticky only through the saturated value; later additions proceed normally.
- Undefined: plain two's-complement wrap on overflow, with no saturation logic.

Test Plan:
All values use n_int=8, n_mant=23 (1.0 = 0x00800000).
1. depth=4, out_ready=1, four samples 1.0+j0.5 (0x00800000, 0x00400000) back-to-back:
   - out_valid for 1 cycle the cycle after the 4th sample
   - resultR=0x02000000, resultI=0x01000000
   - count sequence 0,1,2,3,0
2. depth=4, samples 1.0, -3.0, 0.25 with in_last on the third:
   - resultR=-1.75 (0xFF200000), resultI=0
   - count returns to 0
3. depth=2, out_ready=0 after the first result:
   - in_ready=0
   - result held stable 5 cycles while in_valid stays high
   - raise out_ready: result taken and next sample accepted the same cycle; the new block sums correctly
4. depth=2, two samples of 200.0 (0x64000000):
   - with CFXP_ACC_SAT_EN, resultR=0x7FFFFFFF
   - without it, resultR=-112.0 (0xC8000000)
5. depth=4, rst pulsed after 2 accepted samples, then 4 samples of 1.0:
   - result is 4.0, showing no carry-over from before reset
   - out_valid=0 and result=0 in the cycle after rst
6. depth=1, 8 consecutive samples with random stalls of out_ready:
   - each result equals its input
   - no sample is lost or duplicated

Source files
------------

// File: rtl/cfxp_block_accumulator.sv
// Complex block accumulator: sums blocks of complex products per channel.
// Build option CFXP_ACC_SAT_EN selects saturating instead of wrapping adds.
module cfxp_block_accumulator #(
  parameter int n_int = 8,
  parameter int n_mant = 23,
  parameter int depth = 16,
  localparam int n_tot = n_int + n_mant,
  localparam int CNT_W = $clog2(depth + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [n_tot:0]   inR,
  input  logic signed [n_tot:0]   inI,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [n_tot:0]   resultR,
  output logic signed [n_tot:0]   resultI,
  output logic [CNT_W-1:0]        count
);

  localparam int W = n_tot + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(depth - 1);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t r_state;
  state_t w_state_n;

  logic signed [W-1:0] r_accR;
  logic signed [W-1:0] r_accI;
  logic signed [W-1:0] r_resR;
  logic signed [W-1:0] r_resI;
  logic [CNT_W-1:0]    r_count;

  logic                w_take;
  logic                w_acc_in;
  logic                w_close;
  logic                w_first;
  logic signed [W-1:0] w_sumR;
  logic signed [W-1:0] w_sumI;

`ifdef CFXP_ACC_SAT_EN
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {n_tot{1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {n_tot{1'b0}}};

  // One guard bit detects signed overflow; clamp to the rail.
  function automatic logic signed [W-1:0] f_add(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      f_add = s[W] ? SAT_MIN : SAT_MAX;
    else
      f_add = s[W-1:0];
  endfunction
`else
  function automatic logic signed [W-1:0] f_add(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    f_add = a + b;
  endfunction
`endif

  assign w_take   = out_valid && out_ready;
  assign in_ready = !out_valid || out_ready;
  assign w_acc_in = in_valid && in_ready;
  assign w_first  = (r_count == '0);
  assign w_close  = w_acc_in && (in_last || r_count == LAST);
  assign w_sumR   = w_first ? inR : f_add(r_accR, inR);
  assign w_sumI   = w_first ? inI : f_add(r_accI, inI);

  always_comb begin
    w_state_n = r_state;
    out_valid = 1'b0;
    unique case (r_state)
      S_ACC: begin
        if (w_close)
          w_state_n = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (w_take && !w_close)
          w_state_n = S_ACC;
      end
      default: w_state_n = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACC;
      r_accR  <= '0;
      r_accI  <= '0;
      r_resR  <= '0;
      r_resI  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_acc_in) begin
        if (w_close) begin
          r_resR  <= w_sumR;
          r_resI  <= w_sumI;
          r_count <= '0;
        end else begin
          r_accR  <= w_sumR;
          r_accI  <= w_sumI;
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign resultR = r_resR;
  assign resultI = r_resI;
  assign count   = r_count;

endmodule

// File: tb/tb_cfxp_block_accumulator.sv
// Bench for cfxp_block_accumulator: depth 4, 2 and 1 instances side by side,
// expected block sums queued on stimulus and popped when a result is taken.
module tb_cfxp_block_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] in_valid;
  logic [2:0] in_last;
  logic [2:0] out_ready;
  wire  [2:0] in_ready;
  wire  [2:0] out_valid;
  logic signed [31:0] inR [3];
  logic signed [31:0] inI [3];
  wire  signed [31:0] resR [3];
  wire  signed [31:0] resI [3];
  wire  [2:0] cnt [3];

  int vec = 0;
  int miss = 0;
  logic signed [31:0] qR[$];
  logic signed [31:0] qI[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D  = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    localparam int CW = $clog2(D + 1);
    wire [CW-1:0] c;
    cfxp_block_accumulator #(
      .n_int(8), .n_mant(23), .depth(D)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_last(in_last[g]),
      .inR(inR[g]),
      .inI(inI[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .resultR(resR[g]),
      .resultI(resI[g]),
      .count(c)
    );
    assign cnt[g] = 3'(c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (out_valid[k] !== 1'b0 || resR[k] !== 0 || resI[k] !== 0) begin
        miss++;
        $display("FAIL reset_out[%0d] valid=%b R=%h I=%h want 0/0/0",
                 k, out_valid[k], resR[k], resI[k]);
      end
      vec++;
      if (cnt[k] !== 3'd0 || in_ready[k] !== 1'b1) begin
        miss++;
        $display("FAIL reset_cnt[%0d] count=%0d rdy=%b want 0/1",
                 k, cnt[k], in_ready[k]);
      end
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic signed [31:0] eR, eI;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid[0] = 1'b1;
      in_last[0]  = 1'b0;
      inR[0] = 32'h00800000;
      inI[0] = 32'h00400000;
      if (i == 3) begin
        qR.push_back(32'h02000000);
        qI.push_back(32'h01000000);
      end
      @(negedge clk);
      vec++;
      if (cnt[0] !== 3'(i) || out_valid[0] !== 1'b0) begin
        miss++;
        $display("FAIL basic_cnt%0d count=%0d valid=%b want %0d/0",
                 i, cnt[0], out_valid[0], i);
      end
    end
    tick();
    in_valid[0] = 1'b0;
    inR[0] = 32'h7FFFFFFF;
    inI[0] = 32'h7FFFFFFF;
    @(negedge clk);
    vec++;
    if (out_valid[0] !== 1'b1 || cnt[0] !== 3'd0) begin
      miss++;
      $display("FAIL basic_done valid=%b count=%0d want 1/0",
               out_valid[0], cnt[0]);
    end
    if (out_valid[0] && out_ready[0] && qR.size() > 0) begin
      eR = qR.pop_front();
      eI = qI.pop_front();
      vec++;
      if (resR[0] !== eR || resI[0] !== eI) begin
        miss++;
        $display("FAIL basic_sum got %h/%h want %h/%h",
                 resR[0], resI[0], eR, eI);
      end
    end
    tick();
    @(negedge clk);
    vec++;
    if (out_valid[0] !== 1'b0 || qR.size() != 0) begin
      miss++;
      $display("FAIL basic_pulse valid=%b pending=%0d want 0/0",
               out_valid[0], qR.size());
    end
  endtask

  task automatic test_last();
    logic signed [31:0] s [3];
    logic signed [31:0] eR, eI;
    s[0] = 32'h00800000;
    s[1] = 32'hFE800000;
    s[2] = 32'h00200000;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid[0] = 1'b1;
      in_last[0]  = (i == 2);
      inR[0] = s[i];
      inI[0] = 32'h0;
      if (i == 2) begin
        qR.push_back(32'hFF200000);
        qI.push_back(32'h0);
      end
      @(negedge clk);
    end
    tick();
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    @(negedge clk);
    vec++;
    if (out_valid[0] !== 1'b1 || cnt[0] !== 3'd0) begin
      miss++;
      $display("FAIL last_done valid=%b count=%0d want 1/0",
               out_valid[0], cnt[0]);
    end
    if (out_valid[0] && out_ready[0] && qR.size() > 0) begin
      eR = qR.pop_front();
      eI = qI.pop_front();
      vec++;
      if (resR[0] !== eR || resI[0] !== eI) begin
        miss++;
        $display("FAIL last_sum got %h/%h want %h/%h",
                 resR[0], resI[0], eR, eI);
      end
    end
    qR.delete();
    qI.delete();
  endtask

  task automatic test_stall();
    logic signed [31:0] eR, eI;
    out_ready[1] = 1'b1;
    tick();
    in_valid[1] = 1'b1;
    inR[1] = 32'h00800000;
    inI[1] = 32'h00100000;
    @(negedge clk);
    tick();
    inR[1] = 32'h01000000;
    inI[1] = 32'h00200000;
    qR.push_back(32'h01800000);
    qI.push_back(32'h00300000);
    @(negedge clk);
    tick();
    inR[1] = 32'h00400000;
    inI[1] = 32'hFFF00000;
    out_ready[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      @(negedge clk);
      vec++;
      if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 ||
          qR.size() == 0 || resR[1] !== qR[0] || resI[1] !== qI[0]) begin
        miss++;
        $display("FAIL stall_hold%0d rdy=%b valid=%b R=%h I=%h want 0/1/01800000/00300000",
                 j, in_ready[1], out_valid[1], resR[1], resI[1]);
      end
    end
    tick();
    out_ready[1] = 1'b1;
    @(negedge clk);
    vec++;
    if (in_ready[1] !== 1'b1) begin
      miss++;
      $display("FAIL stall_release rdy=%b want 1", in_ready[1]);
    end
    if (out_valid[1] && out_ready[1] && qR.size() > 0) begin
      eR = qR.pop_front();
      eI = qI.pop_front();
      vec++;
      if (resR[1] !== eR || resI[1] !== eI) begin
        miss++;
        $display("FAIL stall_sum got %h/%h want %h/%h",
                 resR[1], resI[1], eR, eI);
      end
    end
    tick();
    inR[1] = 32'h00400000;
    inI[1] = 32'h00100000;
    qR.push_back(32'h00800000);
    qI.push_back(32'h00000000);
    @(negedge clk);
    vec++;
    if (out_valid[1] !== 1'b0 || cnt[1] !== 3'd1) begin
      miss++;
      $display("FAIL stall_newblk valid=%b count=%0d want 0/1",
               out_valid[1], cnt[1]);
    end
    tick();
    in_valid[1] = 1'b0;
    @(negedge clk);
    vec++;
    if (out_valid[1] !== 1'b1) begin
      miss++;
      $display("FAIL stall_next_valid valid=%b want 1", out_valid[1]);
    end
    if (out_valid[1] && out_ready[1] && qR.size() > 0) begin
      eR = qR.pop_front();
      eI = qI.pop_front();
      vec++;
      if (resR[1] !== eR || resI[1] !== eI) begin
        miss++;
        $display("FAIL stall_next_sum got %h/%h want %h/%h",
                 resR[1], resI[1], eR, eI);
      end
    end
    tick();
    @(negedge clk);
    qR.delete();
    qI.delete();
  endtask

  task automatic test_overflow();
    logic signed [31:0] p [2];
    logic signed [31:0] e [2];
    logic signed [31:0] eR, eI;
    p[0] = 32'h64000000;
    p[1] = 32'h9C000000;
`ifdef CFXP_ACC_SAT_EN
    e[0] = 32'h7FFFFFFF;
    e[1] = 32'h80000000;
`else
    e[0] = 32'hC8000000;
    e[1] = 32'h38000000;
`endif
    out_ready[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 2; i++) begin
        tick();
        in_valid[1] = 1'b1;
        inR[1] = p[t];
        inI[1] = 32'h00100000;
        if (i == 1) begin
          qR.push_back(e[t]);
          qI.push_back(32'h00200000);
        end
        @(negedge clk);
      end
      tick();
      in_valid[1] = 1'b0;
      @(negedge clk);
      vec++;
      if (out_valid[1] !== 1'b1) begin
        miss++;
        $display("FAIL ovf_valid%0d valid=%b want 1", t, out_valid[1]);
      end
      if (out_valid[1] && out_ready[1] && qR.size() > 0) begin
        eR = qR.pop_front();
        eI = qI.pop_front();
        vec++;
        if (resR[1] !== eR || resI[1] !== eI) begin
          miss++;
          $display("FAIL ovf_sum%0d got %h/%h want %h/%h",
                   t, resR[1], resI[1], eR, eI);
        end
      end
    end
    qR.delete();
    qI.delete();
  endtask

  task automatic test_reset_mid();
    logic signed [31:0] eR, eI;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      in_valid[1:0] = 2'b11;
      inR[0] = 32'h00800000;
      inI[0] = 32'h00400000;
      inR[1] = 32'h00800000;
      inI[1] = 32'h00400000;
      @(negedge clk);
    end
    tick();
    in_valid[1:0] = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if (out_valid[1] !== 1'b1 || cnt[0] !== 3'd2) begin
      miss++;
      $display("FAIL rstmid_pre valid1=%b count0=%0d want 1/2",
               out_valid[1], cnt[0]);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (out_valid[0] !== 1'b0 || out_valid[1] !== 1'b0 ||
        resR[1] !== 0 || resI[1] !== 0 || cnt[0] !== 3'd0) begin
      miss++;
      $display("FAIL rstmid_post valid=%b%b R1=%h I1=%h count0=%0d want 00/0/0/0",
               out_valid[1], out_valid[0], resR[1], resI[1], cnt[0]);
    end
    out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      in_valid[0] = 1'b1;
      inR[0] = 32'h00800000;
      inI[0] = 32'h0;
      if (i == 3) begin
        qR.push_back(32'h02000000);
        qI.push_back(32'h0);
      end
      @(negedge clk);
    end
    tick();
    in_valid[0] = 1'b0;
    @(negedge clk);
    vec++;
    if (out_valid[0] !== 1'b1) begin
      miss++;
      $display("FAIL rstmid_valid valid=%b want 1", out_valid[0]);
    end
    if (out_valid[0] && out_ready[0] && qR.size() > 0) begin
      eR = qR.pop_front();
      eI = qI.pop_front();
      vec++;
      if (resR[0] !== eR || resI[0] !== eI) begin
        miss++;
        $display("FAIL rstmid_sum got %h/%h want %h/%h",
                 resR[0], resI[0], eR, eI);
      end
    end
    qR.delete();
    qI.delete();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    bit acc = 1'b0;
    logic signed [31:0] eR, eI;
    in_valid[2] = 1'b0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      tick();
      if (acc) in_valid[2] = 1'b0;
      acc = 1'b0;
      out_ready[2] = 1'($urandom_range(0, 1));
      if (!in_valid[2] && sent < 8) begin
        in_valid[2] = 1'b1;
        in_last[2]  = 1'($urandom_range(0, 1));
        inR[2] = $urandom;
        inI[2] = $urandom;
      end
      @(negedge clk);
      if (out_valid[2] && out_ready[2]) begin
        vec++;
        if (qR.size() == 0) begin
          miss++;
          $display("FAIL d1_extra got %h/%h want none", resR[2], resI[2]);
        end else begin
          eR = qR.pop_front();
          eI = qI.pop_front();
          if (resR[2] !== eR || resI[2] !== eI) begin
            miss++;
            $display("FAIL d1_sample%0d got %h/%h want %h/%h",
                     got, resR[2], resI[2], eR, eI);
          end
        end
        got++;
      end
      if (in_valid[2] && in_ready[2]) begin
        qR.push_back(inR[2]);
        qI.push_back(inI[2]);
        sent++;
        acc = 1'b1;
      end
      vec++;
      if (cnt[2] !== 3'd0) begin
        miss++;
        $display("FAIL d1_count got %0d want 0", cnt[2]);
      end
    end
    vec++;
    if (sent != 8 || got != 8 || qR.size() != 0) begin
      miss++;
      $display("FAIL d1_total sent=%0d got=%0d pending=%0d want 8/8/0",
               sent, got, qR.size());
    end
    tick();
    in_valid[2] = 1'b0;
    in_last[2]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = '1;
    for (int k = 0; k < 3; k++) begin
      inR[k] = '0;
      inI[k] = '0;
    end
    test_reset();
    test_basic();
    test_last();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
